// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the PE controller and its MAC datapath.
package pe_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ACC_W_DEF  = 32;
    localparam int ADDR_W     = 32;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_MAC, S_DONE, S_WRITE} pe_mac_state_t;
endpackage

// File: rtl/pe_mac_unit_if.sv
// pe_mac_unit_if: controller, operand-BRAM and result-write signals of one PE MAC unit.
// sat_flag exists only when PE_SAT_EN is defined.
interface pe_mac_unit_if
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
);
    logic              PE_active;
    logic              vec_fin;
    logic [ADDR_W-1:0] left_mem_index;
    logic [ADDR_W-1:0] right_mem_index;
    logic [ADDR_W-1:0] result_mem_index;
    logic              left_rd_en;
    logic [ADDR_W-1:0] left_rd_addr;
    logic [DATA_W-1:0] left_rd_data;
    logic              right_rd_en;
    logic [ADDR_W-1:0] right_rd_addr;
    logic [DATA_W-1:0] right_rd_data;
    logic              step_fin;
    logic              res_wr_en;
    logic [ADDR_W-1:0] res_wr_addr;
    logic [ACC_W-1:0]  res_wr_data;
    logic              busy;
`ifdef PE_SAT_EN
    logic              sat_flag;
`endif

    modport slave (
        input  PE_active, vec_fin, left_mem_index, right_mem_index, result_mem_index,
               left_rd_data, right_rd_data,
        output left_rd_en, left_rd_addr, right_rd_en, right_rd_addr, step_fin,
               res_wr_en, res_wr_addr, res_wr_data, busy
`ifdef PE_SAT_EN
        , output sat_flag
`endif
    );

    modport master (
        output PE_active, vec_fin, left_mem_index, right_mem_index, result_mem_index,
               left_rd_data, right_rd_data,
        input  left_rd_en, left_rd_addr, right_rd_en, right_rd_addr, step_fin,
               res_wr_en, res_wr_addr, res_wr_data, busy
`ifdef PE_SAT_EN
        , input sat_flag
`endif
    );
endinterface

// File: rtl/pe_mac_acc.sv
// pe_mac_acc: registered signed multiply-accumulate with clear.
// PE_SAT_EN: saturating accumulate with sticky sat_o, cleared together with the accumulator.
module pe_mac_acc #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cap_i,
    input  logic                     mac_i,
    input  logic                     clr_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
`ifdef PE_SAT_EN
    output logic                     sat_o,
`endif
    output logic signed [ACC_W-1:0]  acc_o
);
    logic signed [ACC_W-1:0] prod_q, acc_q, acc_d;
`ifdef PE_SAT_EN
    logic [ACC_W:0] sum;
    logic           ovf, sat_q;
    assign sum   = {acc_q[ACC_W-1], acc_q} + {prod_q[ACC_W-1], prod_q};
    assign ovf   = sum[ACC_W] ^ sum[ACC_W-1];
    assign acc_d = ovf ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
    assign sat_o = sat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_q <= 1'b0;
        else if (clr_i)
            sat_q <= 1'b0;
        else if (mac_i && ovf)
            sat_q <= 1'b1;
    end
`else
    assign acc_d = acc_q + prod_q;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            if (cap_i)
                prod_q <= ACC_W'(a_i * b_i);
            if (clr_i)
                acc_q <= '0;
            else if (mac_i)
                acc_q <= acc_d;
        end
    end
    assign acc_o = acc_q;
endmodule

// File: rtl/pe_mac_unit.sv
// pe_mac_unit: per-PE MAC datapath; fetches operand pair, accumulates, flushes to result memory on vec_fin.
// Define PE_SAT_EN for a saturating accumulator and the sticky bus.sat_flag output.
module pe_mac_unit
    import pe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int RD_LAT = 1
) (
    input logic          clk,
    input logic          rst_n,
    pe_mac_unit_if.slave bus
);
    pe_mac_state_t           state_q, state_d;
    logic [1:0]              wait_q, wait_d;
    logic [ADDR_W-1:0]       l_addr_q, r_addr_q, res_addr_q;
    logic                    pend_q, pend_d, start, wr, cap;
    logic signed [ACC_W-1:0] acc;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE:  state_d = (bus.vec_fin || pend_q) ? S_WRITE : bus.PE_active ? S_FETCH : S_IDLE;
            S_FETCH: begin
                state_d = S_WAIT;
                wait_d  = 2'(RD_LAT - 1);
            end
            S_WAIT: begin
                state_d = (wait_q == '0) ? S_MAC : S_WAIT;
                wait_d  = (wait_q == '0) ? '0 : wait_q - 2'd1;
            end
            S_MAC:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    assign start  = (state_q == S_IDLE) && (state_d == S_FETCH);
    assign wr     = state_q == S_WRITE;
    // read data is on the bus during the last WAIT cycle; MAC then adds the registered product
    assign cap    = (state_q == S_WAIT) && (wait_q == '0);
    assign pend_d = (bus.vec_fin && state_q != S_IDLE) || (pend_q && !wr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_q     <= '0;
            pend_q     <= 1'b0;
            l_addr_q   <= '0;
            r_addr_q   <= '0;
            res_addr_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            pend_q  <= pend_d;
            if (start) begin
                l_addr_q   <= bus.left_mem_index;
                r_addr_q   <= bus.right_mem_index;
                res_addr_q <= bus.result_mem_index;
            end
        end
    end

    pe_mac_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .cap_i (cap),
        .mac_i (state_q == S_MAC),
        .clr_i (wr),
        .a_i   (bus.left_rd_data),
        .b_i   (bus.right_rd_data),
`ifdef PE_SAT_EN
        .sat_o (bus.sat_flag),
`endif
        .acc_o (acc)
    );

    assign bus.left_rd_en    = state_q == S_FETCH;
    assign bus.right_rd_en   = state_q == S_FETCH;
    assign bus.left_rd_addr  = l_addr_q;
    assign bus.right_rd_addr = r_addr_q;
    assign bus.step_fin      = state_q == S_DONE;
    assign bus.res_wr_en     = wr;
    assign bus.res_wr_addr   = wr ? res_addr_q : '0;
    assign bus.res_wr_data   = wr ? acc : '0;
    assign bus.busy          = state_q != S_IDLE;
endmodule
